// File: rtl/idma_axis_stream_accel.sv
// Streaming accelerator stage between the iDMA AXI-Stream write and read ports.
// Each accepted beat is transformed by a per-packet op, registered in a
// one-entry pipe stage and then written into a small output FIFO. The module
// also reports the sum and beat count of the transformed beats of each packet.
//
// Handshake: a beat transfers on a rising clk_i edge where valid and ready are
// both high. valid never waits on ready. Once the output asserts valid, it
// holds data, keep and last stable until the beat is taken. s_axis_tready_o
// is derived only from registered occupancy, so there is no combinational
// path from m_axis_tready_i to s_axis_tready_o.
module idma_axis_stream_accel #(
    parameter int DataWidth = 64,
    parameter int FifoDepth = 4,
    parameter int CntWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic [1:0]             cfg_op_i,
    input  logic [DataWidth-1:0]   cfg_operand_i,
    input  logic [DataWidth-1:0]   s_axis_tdata_i,
    input  logic [DataWidth/8-1:0] s_axis_tkeep_i,
    input  logic                   s_axis_tlast_i,
    input  logic                   s_axis_tvalid_i,
    output logic                   s_axis_tready_o,
    output logic [DataWidth-1:0]   m_axis_tdata_o,
    output logic [DataWidth/8-1:0] m_axis_tkeep_o,
    output logic                   m_axis_tlast_o,
    output logic                   m_axis_tvalid_o,
    input  logic                   m_axis_tready_i,
    output logic                   pkt_done_o,
    output logic [DataWidth-1:0]   pkt_sum_o,
    output logic [CntWidth-1:0]    pkt_beats_o
);

    localparam int KeepWidth = DataWidth / 8;
    localparam int PtrWidth  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccWidth  = $clog2(FifoDepth + 1) + 1;

    // Packet framing state; state_q is the observable FSM state for checkers.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   sample_cfg;
    logic                   s_hs, m_hs;
    logic [1:0]             op_q, op_eff;
    logic [DataWidth-1:0]   operand_q, operand_eff;
    logic [DataWidth-1:0]   xform_data;

    logic                   pipe_valid_q;
    logic [DataWidth-1:0]   pipe_data_q;
    logic [KeepWidth-1:0]   pipe_keep_q;
    logic                   pipe_last_q;

    logic [DataWidth-1:0]   mem_data [FifoDepth];
    logic [KeepWidth-1:0]   mem_keep [FifoDepth];
    logic                   mem_last [FifoDepth];
    logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OccWidth-1:0]    fifo_count_q, occupancy;
    logic                   fifo_empty;

    logic [DataWidth-1:0]   sum_acc_q, sum_next;
    logic [CntWidth-1:0]    beats_acc_q, beats_next;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // The pipe register always drains into the FIFO on the next edge, so the
    // pipe entry must be counted as occupied when deciding input readiness.
    assign occupancy       = fifo_count_q + OccWidth'(pipe_valid_q);
    assign s_axis_tready_o = !rst && (occupancy < OccWidth'(FifoDepth));
    assign s_hs            = s_axis_tvalid_i && s_axis_tready_o;
    assign fifo_empty      = (fifo_count_q == '0);
    assign m_axis_tvalid_o = !fifo_empty;
    assign m_hs            = m_axis_tvalid_o && m_axis_tready_i;
    assign m_axis_tdata_o  = fifo_empty ? '0 : mem_data[rd_ptr_q];
    assign m_axis_tkeep_o  = fifo_empty ? '0 : mem_keep[rd_ptr_q];
    assign m_axis_tlast_o  = fifo_empty ? 1'b0 : mem_last[rd_ptr_q];

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a packet opens on a non-last beat and closes on tlast.
    always_comb begin
        state_d = state_q;
        if (s_hs) state_d = s_axis_tlast_i ? ST_IDLE : ST_IN_PKT;
    end

    // FSM outputs: the configuration is taken live only on a packet's first beat.
    always_comb begin
        sample_cfg = (state_q == ST_IDLE);
    end

    // Latch op and operand on the first beat so mid-packet cfg changes are ignored.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            op_q      <= 2'd0;
            operand_q <= '0;
        end else if (s_hs && sample_cfg) begin
            op_q      <= cfg_op_i;
            operand_q <= cfg_operand_i;
        end
    end

    assign op_eff      = sample_cfg ? cfg_op_i : op_q;
    assign operand_eff = sample_cfg ? cfg_operand_i : operand_q;

    // Beat transform on the whole word, independent of tkeep.
    always_comb begin
        xform_data = s_axis_tdata_i;
        case (op_eff)
            2'd1: xform_data = s_axis_tdata_i + operand_eff;
            2'd2: xform_data = s_axis_tdata_i ^ operand_eff;
            2'd3: begin
                for (int i = 0; i < KeepWidth; i++) begin
                    xform_data[i*8 +: 8] = s_axis_tdata_i[(KeepWidth-1-i)*8 +: 8];
                end
            end
            default: ;
        endcase
    end

    // Pipe stage holding the transformed beat for one cycle.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            pipe_keep_q  <= '0;
            pipe_last_q  <= 1'b0;
        end else begin
            pipe_valid_q <= s_hs;
            if (s_hs) begin
                pipe_data_q <= xform_data;
                pipe_keep_q <= s_axis_tkeep_i;
                pipe_last_q <= s_axis_tlast_i;
            end
        end
    end

    // FIFO storage; contents are masked at the outputs while empty.
    always_ff @(posedge clk_i) begin
        if (pipe_valid_q) begin
            mem_data[wr_ptr_q] <= pipe_data_q;
            mem_keep[wr_ptr_q] <= pipe_keep_q;
            mem_last[wr_ptr_q] <= pipe_last_q;
        end
    end

    // FIFO pointers and count; a push and pop in the same cycle cancel out.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (pipe_valid_q) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (m_hs)         rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (pipe_valid_q && !m_hs)      fifo_count_q <= fifo_count_q + OccWidth'(1);
            else if (!pipe_valid_q && m_hs) fifo_count_q <= fifo_count_q - OccWidth'(1);
        end
    end

    assign sum_next   = sum_acc_q + pipe_data_q;
    assign beats_next = (&beats_acc_q) ? beats_acc_q : beats_acc_q + CntWidth'(1);

    // Per-packet statistics, published when the last beat leaves the pipe.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sum_acc_q   <= '0;
            beats_acc_q <= '0;
            pkt_sum_o   <= '0;
            pkt_beats_o <= '0;
            pkt_done_o  <= 1'b0;
        end else begin
            pkt_done_o <= 1'b0;
            if (pipe_valid_q) begin
                if (pipe_last_q) begin
                    pkt_sum_o   <= sum_next;
                    pkt_beats_o <= beats_next;
                    pkt_done_o  <= 1'b1;
                    sum_acc_q   <= '0;
                    beats_acc_q <= '0;
                end else begin
                    sum_acc_q   <= sum_next;
                    beats_acc_q <= beats_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_idma_axis_stream_accel.sv
// Bench for idma_axis_stream_accel: drivers push expected beats and packet
// statistics into queues, a monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_idma_axis_stream_accel;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int CW = 16;
    localparam int EW = DW + KW + 1;

    // Clock and reset
    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_i = ~clk_i;

    logic [1:0]    cfg_op_i;
    logic [DW-1:0] cfg_operand_i;
    logic [DW-1:0] s_axis_tdata_i;
    logic [KW-1:0] s_axis_tkeep_i;
    logic          s_axis_tlast_i;
    logic          s_axis_tvalid_i;
    logic          s_axis_tready_o;
    logic [DW-1:0] m_axis_tdata_o;
    logic [KW-1:0] m_axis_tkeep_o;
    logic          m_axis_tlast_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tready_i;
    logic          pkt_done_o;
    logic [DW-1:0] pkt_sum_o;
    logic [CW-1:0] pkt_beats_o;

    idma_axis_stream_accel #(.DataWidth(DW), .FifoDepth(4), .CntWidth(CW)) dut (
        .clk_i           (clk_i),
        .rst             (rst),
        .cfg_op_i        (cfg_op_i),
        .cfg_operand_i   (cfg_operand_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tkeep_i  (s_axis_tkeep_i),
        .s_axis_tlast_i  (s_axis_tlast_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tkeep_o  (m_axis_tkeep_o),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .pkt_done_o      (pkt_done_o),
        .pkt_sum_o       (pkt_sum_o),
        .pkt_beats_o     (pkt_beats_o)
    );

    // Scoreboard state
    logic [EW-1:0]    exp_q[$];
    logic [DW+CW-1:0] stat_q[$];
    int               n_checks = 0;
    int               n_fail = 0;
    int               accepted_cnt = 0;
    int               done_cnt = 0;
    int               rdy_mode = 0;
    logic [DW-1:0]    model_sum = '0;
    int               model_beats = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference transform straight from the op definitions.
    function automatic logic [DW-1:0] ref_xform(logic [1:0] op, logic [DW-1:0] operand,
                                                logic [DW-1:0] d);
        logic [DW-1:0] r;
        case (op)
            2'd0: r = d;
            2'd1: r = d + operand;
            2'd2: r = d ^ operand;
            default: r = {<<8{d}};
        endcase
        return r;
    endfunction

    // Output ready driver: 0 always high, 1 random, 2 held low.
    initial begin
        m_axis_tready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                1:       m_axis_tready_i = 1'($urandom_range(0, 1));
                2:       m_axis_tready_i = 1'b0;
                default: m_axis_tready_i = 1'b1;
            endcase
        end
    end

    // Drive one beat until accepted; record the expected output and stats.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [DW-1:0] e);
        bit ok;
        ok = 1'b0;
        s_axis_tdata_i  = d;
        s_axis_tkeep_i  = k;
        s_axis_tlast_i  = l;
        s_axis_tvalid_i = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            if (s_axis_tready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("s_tready_wait", 128'(ok), 128'(1));
        if (ok) begin
            exp_q.push_back({e, k, l});
            accepted_cnt++;
            model_sum = model_sum + e;
            model_beats++;
            if (l) begin
                stat_q.push_back({model_sum, (model_beats > 65535) ? 16'hFFFF : CW'(model_beats)});
                model_sum   = '0;
                model_beats = 0;
            end
        end
        @(posedge clk_i);
        #1;
        s_axis_tvalid_i = 1'b0;
    endtask

    // Send a packet; dmode 0 = data 1..n with full keep, 1 = random data/keep.
    // At beat chg_at the cfg inputs are disturbed, which must not affect the packet.
    task automatic send_packet(input int n, input logic [1:0] op, input logic [DW-1:0] operand,
                               input int dmode, input int chg_at, input int gap_max);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk_i);
                #1;
            end
            if (dmode == 0) begin
                d = DW'(i + 1);
                k = '1;
            end else begin
                d = {$urandom, $urandom};
                k = KW'($urandom);
            end
            if (i == 0) begin
                cfg_op_i      = op;
                cfg_operand_i = operand;
            end
            if (i == chg_at) begin
                cfg_op_i      = 2'd1;
                cfg_operand_i = {$urandom, $urandom};
            end
            send_beat(d, k, (i == n - 1), ref_xform(op, operand, d));
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && stat_q.size() == 0 && !m_axis_tvalid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 128'(ok), 128'(1));
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare emitted beats and packet stats against the queues.
    initial begin
        logic [EW-1:0]    prev_word, cur_word, exp_word;
        logic [DW+CW-1:0] st;
        logic             prev_stall;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk_i);
            cur_word = {m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_tvalid", 128'(m_axis_tvalid_o), 128'(1));
                    check("hold_beat", 128'(cur_word), 128'(prev_word));
                end
                if (m_axis_tvalid_o && m_axis_tready_i) begin
                    check("beat_expected", 128'(exp_q.size() > 0), 128'(1));
                    if (exp_q.size() > 0) begin
                        exp_word = exp_q.pop_front();
                        check("out_beat", 128'(cur_word), 128'(exp_word));
                    end
                end
                prev_stall = m_axis_tvalid_o && !m_axis_tready_i;
                prev_word  = cur_word;
                if (pkt_done_o) begin
                    done_cnt++;
                    check("pkt_done_expected", 128'(stat_q.size() > 0), 128'(1));
                    if (stat_q.size() > 0) begin
                        st = stat_q.pop_front();
                        check("pkt_sum", 128'(pkt_sum_o), 128'(st[DW+CW-1:CW]));
                        check("pkt_beats", 128'(pkt_beats_o), 128'(st[CW-1:0]));
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int base_done, base_acc;
        logic [DW-1:0] xsum;
        cfg_op_i        = 2'd0;
        cfg_operand_i   = '0;
        s_axis_tdata_i  = '0;
        s_axis_tkeep_i  = '0;
        s_axis_tlast_i  = 1'b0;
        s_axis_tvalid_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst_s_tready", 128'(s_axis_tready_o), 128'(0));
        check("rst_m_tvalid", 128'(m_axis_tvalid_o), 128'(0));
        check("rst_m_tdata", 128'(m_axis_tdata_o), 128'(0));
        check("rst_pkt_done", 128'(pkt_done_o), 128'(0));
        check("rst_pkt_sum", 128'(pkt_sum_o), 128'(0));
        check("rst_pkt_beats", 128'(pkt_beats_o), 128'(0));
        repeat (2) @(posedge clk_i);
        #1;
        rst = 1'b0;
        @(negedge clk_i);
        check("s_tready_after_rst", 128'(s_axis_tready_o), 128'(1));
        @(posedge clk_i);
        #1;

        // Test 1: add 1 to data 1..16
        base_done = done_cnt;
        send_packet(16, 2'd1, 64'd1, 0, -1, 0);
        wait_drain();
        check("t1_pkt_sum", 128'(pkt_sum_o), 128'(64'h98));
        check("t1_pkt_beats", 128'(pkt_beats_o), 128'(16));
        check("t1_done_pulses", 128'(done_cnt - base_done), 128'(1));

        // Test 2: byte reverse single beat, 2-cycle latency
        cfg_op_i      = 2'd3;
        cfg_operand_i = '0;
        send_beat(64'h0102030405060708, 8'hFF, 1'b1, ref_xform(2'd3, '0, 64'h0102030405060708));
        @(negedge clk_i);
        check("t2_tvalid_edge_k", 128'(m_axis_tvalid_o), 128'(0));
        @(negedge clk_i);
        check("t2_tvalid_edge_k1", 128'(m_axis_tvalid_o), 128'(1));
        check("t2_tdata", 128'(m_axis_tdata_o), 128'(64'h0807060504030201));
        wait_drain();
        check("t2_pkt_sum", 128'(pkt_sum_o), 128'(64'h0807060504030201));
        check("t2_pkt_beats", 128'(pkt_beats_o), 128'(1));

        // Test 3: output stalled, input fills to FIFO depth
        rdy_mode = 2;
        repeat (2) @(posedge clk_i);
        #1;
        base_acc = accepted_cnt;
        fork
            send_packet(8, 2'd0, '0, 1, -1, 0);
            begin
                repeat (20) @(negedge clk_i);
                check("t3_accepted_stalled", 128'(accepted_cnt - base_acc), 128'(4));
                check("t3_s_tready_low", 128'(s_axis_tready_o), 128'(0));
                rdy_mode = 0;
            end
        join
        wait_drain();
        check("t3_accepted_total", 128'(accepted_cnt - base_acc), 128'(8));

        // Test 4: op latched at beat 0, cfg change mid-packet ignored
        send_packet(16, 2'd2, 64'hFF, 0, 5, 0);
        wait_drain();
        xsum = '0;
        for (int i = 1; i <= 16; i++) xsum = xsum + (DW'(i) ^ 64'hFF);
        check("t4_pkt_sum", 128'(pkt_sum_o), 128'(xsum));
        send_packet(16, 2'd1, 64'hFF, 0, -1, 0);
        wait_drain();
        check("t4_next_pkt_sum", 128'(pkt_sum_o), 128'(64'h98 + 64'hFF * 16 - 64'd16));

        // Test 5: reset mid-packet
        base_done = done_cnt;
        cfg_op_i  = 2'd0;
        for (int i = 0; i < 6; i++) send_beat(DW'(i + 1), '1, 1'b0, DW'(i + 1));
        rst = 1'b1;
        exp_q.delete();
        stat_q.delete();
        model_sum   = '0;
        model_beats = 0;
        @(negedge clk_i);
        check("t5_s_tready", 128'(s_axis_tready_o), 128'(0));
        check("t5_m_tvalid", 128'(m_axis_tvalid_o), 128'(0));
        check("t5_m_tdata", 128'(m_axis_tdata_o), 128'(0));
        check("t5_m_tkeep", 128'(m_axis_tkeep_o), 128'(0));
        check("t5_m_tlast", 128'(m_axis_tlast_o), 128'(0));
        check("t5_pkt_sum", 128'(pkt_sum_o), 128'(0));
        check("t5_pkt_beats", 128'(pkt_beats_o), 128'(0));
        @(posedge clk_i);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk_i);
        check("t5_fifo_empty", 128'(m_axis_tvalid_o), 128'(0));
        check("t5_no_pkt_done", 128'(done_cnt - base_done), 128'(0));
        @(posedge clk_i);
        #1;
        send_packet(16, 2'd0, '0, 0, -1, 0);
        wait_drain();
        check("t5_pkt_beats_after", 128'(pkt_beats_o), 128'(16));

        // Test 6: random valid/ready, pass-through packets
        rdy_mode = 1;
        for (int p = 0; p < 200; p++) begin
            send_packet($urandom_range(1, 32), 2'd0, {$urandom, $urandom}, 1, -1, 2);
        end
        for (int p = 0; p < 20; p++) begin
            int n;
            n = $urandom_range(1, 32);
            send_packet(n, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1,
                        (n > 1) ? $urandom_range(1, n - 1) : -1, 2);
        end
        rdy_mode = 0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
